// File: rtl/mux_rr_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : mux_rr_arbiter_if
// Purpose  : Bundles the four requester inputs, the per-requester accept
//            strobes, the grant/select status and the shared valid/ready
//            output path of mux_rr_arbiter.
// Signals  : req[3:0]      requester valid, held while data is pending
//            in0..in3      requester data (WIDTH bits each)
//            in_ready[3:0] per-requester beat accept (combinational)
//            grant[3:0]    registered one-hot grant, zero when idle
//            sel[1:0]      registered index of the granted requester
//            out_valid     registered output valid
//            out_data      registered output data (WIDTH bits)
//            out_ready     downstream ready
// Modports : master - the arbiter side (drives grant, sel, out_*, in_ready)
//            slave  - the producers/sink side
// Revision : 1.0 - initial release
// ============================================================================
interface mux_rr_arbiter_if #(
  parameter int WIDTH = 4
);
  logic [3:0]       req;
  logic [WIDTH-1:0] in0;
  logic [WIDTH-1:0] in1;
  logic [WIDTH-1:0] in2;
  logic [WIDTH-1:0] in3;
  logic [3:0]       in_ready;
  logic [3:0]       grant;
  logic [1:0]       sel;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready;

  modport master (
    input  req, in0, in1, in2, in3, out_ready,
    output in_ready, grant, sel, out_valid, out_data
  );

  modport slave (
    output req, in0, in1, in2, in3, out_ready,
    input  in_ready, grant, sel, out_valid, out_data
  );
endinterface
`default_nettype wire

// File: rtl/mux_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mux_rr_arbiter
// Purpose  : Round-robin arbiter driving a registered 4:1 data mux. One
//            requester is granted at a time; its beat is captured into a
//            single output register and offered downstream over valid/ready.
// Ports    : clk    - rising-edge clock
//            reset  - asynchronous, active-high reset
//            bus    - mux_rr_arbiter_if.master (req, in0..in3, in_ready,
//                     grant, sel, out_valid, out_data, out_ready)
// Params   : WIDTH     - data width of each requester and of out_data
//            MAX_BURST - beats per grant (1..15), only used with
//                        MUX_ARB_HOLD_EN
// Options  : MUX_ARB_HOLD_EN - when defined, a grant is held on the same
//            requester for up to MAX_BURST accepted beats before rotating.
//            When undefined, the grant rotates after every accepted beat.
// Revision : 1.0 - initial release
// ============================================================================
module mux_rr_arbiter #(
  parameter int WIDTH     = 4,
  parameter int MAX_BURST = 4
) (
  input  logic             clk,
  input  logic             reset,
  mux_rr_arbiter_if.master bus
);

  if (MAX_BURST < 1 || MAX_BURST > 15) begin : g_burst_range_check
    $error("mux_rr_arbiter: MAX_BURST must be in the range 1..15");
  end

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [3:0]       r_grant;
  logic [3:0]       w_grant_nxt;
  logic [1:0]       r_sel;
  logic [1:0]       w_sel_nxt;
  logic [1:0]       r_ptr;
  logic [1:0]       w_ptr_nxt;
  logic             r_out_valid;
  logic             w_out_valid_nxt;
  logic [WIDTH-1:0] r_out_data;
  logic [WIDTH-1:0] w_out_data_nxt;
  logic [WIDTH-1:0] w_in_sel;
  logic             w_space;
  logic             w_accept;
  logic             w_withdraw;
  logic             w_rotate;
  // {found, index} results of the three possible searches
  logic [2:0]       w_pick_ptr;
  logic [2:0]       w_pick_rot;
  logic [2:0]       w_pick_wd;

`ifdef MUX_ARB_HOLD_EN
  localparam logic [4:0] c_burst_lim = 5'(MAX_BURST);
  logic [3:0]       r_cnt;
  logic [3:0]       w_cnt_nxt;
`endif

  // Round-robin search: start, start+1, ... mod 4; first set bit wins.
  // Walking from the lowest priority upwards lets the highest one land last.
  function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] start);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    for (int k = 3; k >= 0; k--) begin
      idx = start + 2'(k);
      if (r[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  // The output register can take a beat if it is empty or draining this cycle.
  assign w_space    = ~r_out_valid | bus.out_ready;
  assign w_accept   = (r_state == ST_BUSY) & bus.req[r_sel] & w_space;
  assign w_withdraw = (r_state == ST_BUSY) & ~bus.req[r_sel];

  assign w_pick_ptr = rr_pick(bus.req, r_ptr);
  // After an accept the served requester sits at the lowest priority slot
  // but stays eligible.
  assign w_pick_rot = rr_pick(bus.req, r_sel + 2'd1);
  // On withdraw the granted requester is masked out of the search.
  assign w_pick_wd  = rr_pick(bus.req & ~r_grant, r_sel + 2'd1);

  always_comb begin
    w_in_sel = bus.in0;
    case (r_sel)
      2'd0:    w_in_sel = bus.in0;
      2'd1:    w_in_sel = bus.in1;
      2'd2:    w_in_sel = bus.in2;
      default: w_in_sel = bus.in3;
    endcase
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_grant_nxt     = r_grant;
    w_sel_nxt       = r_sel;
    w_ptr_nxt       = r_ptr;
    w_out_valid_nxt = r_out_valid & ~bus.out_ready;
    w_out_data_nxt  = r_out_data;
    w_rotate        = 1'b0;
`ifdef MUX_ARB_HOLD_EN
    w_cnt_nxt       = r_cnt;
`endif

    // A new accept overwrites the output register even while it drains,
    // so back-to-back beats flow without a bubble.
    if (w_accept) begin
      w_out_valid_nxt = 1'b1;
      w_out_data_nxt  = w_in_sel;
    end

    case (r_state)
      ST_IDLE: begin
        if (w_pick_ptr[2]) begin
          w_state_nxt = ST_BUSY;
          w_grant_nxt = 4'b0001 << w_pick_ptr[1:0];
          w_sel_nxt   = w_pick_ptr[1:0];
        end
      end
      ST_BUSY: begin
        if (w_accept) begin
`ifdef MUX_ARB_HOLD_EN
          if (({1'b0, r_cnt} + 5'd1) < c_burst_lim) begin
            w_cnt_nxt = r_cnt + 4'd1;
          end else begin
            w_rotate = 1'b1;
          end
`else
          w_rotate = 1'b1;
`endif
        end else if (w_withdraw) begin
`ifdef MUX_ARB_HOLD_EN
          w_cnt_nxt = 4'd0;
`endif
          if (w_pick_wd[2]) begin
            w_grant_nxt = 4'b0001 << w_pick_wd[1:0];
            w_sel_nxt   = w_pick_wd[1:0];
          end else begin
            w_state_nxt = ST_IDLE;
            w_grant_nxt = 4'b0000;
            w_sel_nxt   = 2'd0;
          end
        end
        // Otherwise backpressured: grant, sel and data hold.

        if (w_rotate) begin
          w_ptr_nxt = r_sel + 2'd1;
`ifdef MUX_ARB_HOLD_EN
          w_cnt_nxt = 4'd0;
`endif
          if (w_pick_rot[2]) begin
            w_grant_nxt = 4'b0001 << w_pick_rot[1:0];
            w_sel_nxt   = w_pick_rot[1:0];
          end else begin
            w_state_nxt = ST_IDLE;
            w_grant_nxt = 4'b0000;
            w_sel_nxt   = 2'd0;
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_grant_nxt = 4'b0000;
        w_sel_nxt   = 2'd0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_grant     <= 4'b0000;
      r_sel       <= 2'd0;
      r_ptr       <= 2'd0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_grant     <= w_grant_nxt;
      r_sel       <= w_sel_nxt;
      r_ptr       <= w_ptr_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_out_data  <= w_out_data_nxt;
    end
  end

`ifdef MUX_ARB_HOLD_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= 4'd0;
    end else begin
      r_cnt <= w_cnt_nxt;
    end
  end
`endif

  assign bus.in_ready  = r_grant & {4{w_space}};
  assign bus.grant     = r_grant;
  assign bus.sel       = r_sel;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;

endmodule
`default_nettype wire

// File: tb/tb_mux_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mux_rr_arbiter
// Purpose  : Directed self-checking bench for mux_rr_arbiter. Expected beats
//            are queued as stimulus is applied and popped by a monitor on
//            every completed out_valid/out_ready transfer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mux_rr_arbiter;

  localparam int WIDTH = 4;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  logic [WIDTH-1:0] sb[$];

  mux_rr_arbiter_if #(.WIDTH(WIDTH)) bus ();

  mux_rr_arbiter #(
    .WIDTH     (WIDTH),
    .MAX_BURST (2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Transfer monitor and structural invariants, sampled mid-cycle.
  always @(negedge clk) begin
    if (!reset) begin
      check("grant_onehot0", 8'($onehot0(bus.grant)), 8'd1);
      check("in_ready_onehot0", 8'($onehot0(bus.in_ready)), 8'd1);
      if (bus.grant == 4'b0000) check("sel_idle", 8'(bus.sel), 8'd0);
      else check("sel_matches_grant", 8'(bus.grant), 8'(4'b0001 << bus.sel));
      if (bus.out_valid && bus.out_ready) begin
        checks++;
        assert (sb.size() > 0) else begin
          errors++;
          $error("FAIL sb_underflow: observed beat %0h expected none", bus.out_data);
        end
        if (sb.size() > 0) check("beat_data", 8'(bus.out_data), 8'(sb.pop_front()));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [WIDTH-1:0] burst_exp [4];
    checks = 0;
    errors = 0;
    reset = 1'b1;
    bus.req = 4'b0000;
    bus.in0 = '0; bus.in1 = '0; bus.in2 = '0; bus.in3 = '0;
    bus.out_ready = 1'b0;
    tick();
    tick();

    // ---- reset state ----
    check("rst_grant", 8'(bus.grant), 8'h0);
    check("rst_sel", 8'(bus.sel), 8'h0);
    check("rst_valid", 8'(bus.out_valid), 8'h0);
    check("rst_data", 8'(bus.out_data), 8'h0);
    check("rst_in_ready", 8'(bus.in_ready), 8'h0);
    reset = 1'b0;

    // ---- reset mid-transfer ----
    bus.in0 = 4'hA;
    bus.req = 4'b0001;
    tick();
    check("p1_grant", 8'(bus.grant), 8'h1);
    tick();
    check("p1_valid", 8'(bus.out_valid), 8'h1);
    check("p1_data", 8'(bus.out_data), 8'hA);
    #2 reset = 1'b1;
    #1;
    check("async_rst_grant", 8'(bus.grant), 8'h0);
    check("async_rst_sel", 8'(bus.sel), 8'h0);
    check("async_rst_valid", 8'(bus.out_valid), 8'h0);
    check("async_rst_data", 8'(bus.out_data), 8'h0);
    bus.req = 4'b0100;
    bus.in2 = 4'h3;
    #2 reset = 1'b0;
    tick();
    check("post_rst_grant", 8'(bus.grant), 8'h4);
    check("post_rst_sel", 8'(bus.sel), 8'h2);
    bus.req = 4'b0000;
    tick();
    check("p1_idle", 8'(bus.grant), 8'h0);

    // ---- fairness with four continuous requesters ----
    bus.in0 = 4'h1; bus.in1 = 4'h2; bus.in2 = 4'h3; bus.in3 = 4'h4;
    bus.out_ready = 1'b1;
    bus.req = 4'b1111;
    sb.push_back(4'h1); sb.push_back(4'h2); sb.push_back(4'h3);
    sb.push_back(4'h4); sb.push_back(4'h1);
    for (int i = 0; i < 6; i++) begin
      tick();
      check("rr_grant", 8'(bus.grant), 8'(4'b0001 << (i % 4)));
    end
    bus.req = 4'b0000;
    tick();
    check("p2_idle", 8'(bus.grant), 8'h0);
    check("p2_valid_clr", 8'(bus.out_valid), 8'h0);

    // ---- backpressure ----
    bus.req = 4'b0010;
    bus.in1 = 4'h5;
    sb.push_back(4'h5);
    tick();
    check("bp_grant0", 8'(bus.grant), 8'h2);
    tick();
    bus.out_ready = 1'b0;
    bus.in1 = 4'h6;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_data", 8'(bus.out_data), 8'h5);
      check("bp_valid", 8'(bus.out_valid), 8'h1);
      check("bp_grant", 8'(bus.grant), 8'h2);
      check("bp_sel", 8'(bus.sel), 8'h1);
      check("bp_in_ready", 8'(bus.in_ready), 8'h0);
    end
    sb.push_back(4'h6);
    bus.out_ready = 1'b1;
    #1;
    check("bp_release_in_ready", 8'(bus.in_ready), 8'h2);
    tick();
    check("bp_next_data", 8'(bus.out_data), 8'h6);
    check("bp_next_valid", 8'(bus.out_valid), 8'h1);
    bus.req = 4'b0000;
    tick();
    check("p3_idle", 8'(bus.grant), 8'h0);
    check("p3_valid_clr", 8'(bus.out_valid), 8'h0);

    // ---- withdraw and skip (set ptr=1 by serving requester 0) ----
    bus.req = 4'b0001;
    bus.in0 = 4'h7;
    sb.push_back(4'h7);
    tick();
    check("wd_setup_grant", 8'(bus.grant), 8'h1);
    tick();
    bus.req = 4'b0000;
    tick();
    bus.req = 4'b0101;
    tick();
    check("wd_grant2", 8'(bus.grant), 8'h4);
    check("wd_sel2", 8'(bus.sel), 8'h2);
    bus.req = 4'b0001;
    tick();
    check("wd_skip_grant", 8'(bus.grant), 8'h1);
    check("wd_skip_sel", 8'(bus.sel), 8'h0);
    bus.req = 4'b0000;
    tick();
    check("wd_idle", 8'(bus.grant), 8'h0);
    bus.req = 4'b0101;
    tick();
    check("wd_ptr_kept", 8'(bus.grant), 8'h4);
    bus.req = 4'b0000;
    tick();

    // ---- lone continuous requester ----
    bus.req = 4'b1000;
    bus.in3 = 4'h9;
    tick();
    check("lone_grant0", 8'(bus.grant), 8'h8);
    for (int i = 0; i < 4; i++) begin
      bus.in3 = 4'(9 + i);
      sb.push_back(4'(9 + i));
      tick();
      check("lone_grant", 8'(bus.grant), 8'h8);
      check("lone_valid", 8'(bus.out_valid), 8'h1);
      check("lone_data", 8'(bus.out_data), 8'(9 + i));
    end
    bus.req = 4'b0000;
    tick();
    check("p5_idle", 8'(bus.grant), 8'h0);

    // ---- burst hold / rotation with two requesters ----
`ifdef MUX_ARB_HOLD_EN
    burst_exp[0] = 4'h1; burst_exp[1] = 4'h1; burst_exp[2] = 4'h2; burst_exp[3] = 4'h2;
`else
    burst_exp[0] = 4'h1; burst_exp[1] = 4'h2; burst_exp[2] = 4'h1; burst_exp[3] = 4'h2;
`endif
    bus.in0 = 4'h1;
    bus.in1 = 4'h2;
    bus.req = 4'b0011;
    for (int i = 0; i < 4; i++) sb.push_back(burst_exp[i]);
    tick();
    check("burst_grant0", 8'(bus.grant), 8'h1);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("burst_data", 8'(bus.out_data), 8'(burst_exp[i]));
    end
    bus.req = 4'b0000;
    tick();
    check("p6_idle", 8'(bus.grant), 8'h0);
    tick();
    check("sb_drained", 8'(sb.size()), 8'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
